ninjakun_snd_filter: RTL and testbench



---
 rtl/ninjakun_snd_filter.sv | 103 ++++++++++
 tb/tb_ninjakun_snd_filter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ninjakun_snd_filter.sv
// ninjakun_snd_filter: decimates the PSG mix, optionally removes DC, low-passes and saturates.
// Build option: define SNDFLT_DCBLOCK_EN to include the DC blocker in stage A.
module ninjakun_snd_filter #(
    parameter int DIV      = 500,
    parameter int DC_SHIFT = 10,
    parameter int LP_SHIFT = 2
) (
    input  logic        SHCLK,
    input  logic        RESET,
    input  logic [15:0] SNDIN,
    input  logic        MUTE,
    input  logic        pause,
    output logic [15:0] SNDOUT,
    output logic        SNDSTB
);

    if (DIV < 4 || DIV > 4095 || LP_SHIFT < 0 || LP_SHIFT > 8 || DC_SHIFT < 1 || DC_SHIFT > 23)
    begin : g_bad_param
        $error("ninjakun_snd_filter: parameter out of range");
    end

    localparam logic [11:0] CNT_LAST = 12'(DIV - 1);

    logic [11:0]        cnt;
    logic               tick;
    logic               vs;
    logic               va;
    logic               stb;
    logic signed [23:0] x_in;
    logic signed [23:0] x;
    logic signed [23:0] d_next;
    logic signed [23:0] d;
    logic signed [23:0] l_next;
    logic signed [23:0] l;
    logic [15:0]        l_sat;

    assign tick = (cnt == CNT_LAST) && !pause;

    // Offset-binary to two's complement is an MSB flip, then sign-extend.
    assign x_in = MUTE ? 24'sd0 : {{9{~SNDIN[15]}}, SNDIN[14:0]};

`ifdef SNDFLT_DCBLOCK_EN
    logic signed [23:0] xp;
    logic signed [23:0] yp;

    assign d_next = x - xp + yp - (yp >>> DC_SHIFT);
`else
    assign d_next = x;
`endif

    assign l_next = l + ((d - l) >>> LP_SHIFT);

    always_comb begin
        if (l_next > 24'sd32767) begin
            l_sat = 16'h7fff;
        end else if (l_next < -24'sd32768) begin
            l_sat = 16'h8000;
        end else begin
            l_sat = l_next[15:0];
        end
    end

    always_ff @(posedge SHCLK) begin
        if (RESET) begin
            cnt    <= 12'd0;
            vs     <= 1'b0;
            va     <= 1'b0;
            stb    <= 1'b0;
            x      <= 24'sd0;
            d      <= 24'sd0;
            l      <= 24'sd0;
            SNDOUT <= 16'h0000;
`ifdef SNDFLT_DCBLOCK_EN
            xp     <= 24'sd0;
            yp     <= 24'sd0;
`endif
        end else if (!pause) begin
            cnt <= (cnt == CNT_LAST) ? 12'd0 : cnt + 12'd1;
            vs  <= tick;
            va  <= vs;
            stb <= va;
            if (tick) begin
                x <= x_in;
            end
            if (vs) begin
                d  <= d_next;
`ifdef SNDFLT_DCBLOCK_EN
                xp <= x;
                yp <= d_next;
`endif
            end
            // Output register is loaded together with l so SNDOUT and SNDSTB line up.
            if (va) begin
                l      <= l_next;
                SNDOUT <= l_sat;
            end
        end
    end

    // stb survives a pause so a strobe falling due during it is delivered on release.
    assign SNDSTB = stb && !pause;

endmodule

// File: tb/tb_ninjakun_snd_filter.sv
// Self-checking bench for ninjakun_snd_filter: vector table, corner sequences and a
// per-sample arithmetic reference model checked every cycle under random stimulus.
module tb_ninjakun_snd_filter;

    localparam int DIV      = 500;
    localparam int DC_SHIFT = 10;
    localparam int LP_SHIFT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mute;
    logic        pause;
    logic [15:0] sndin;
    logic [15:0] sndout;
    logic        stb;

    logic        rst2;
    logic [15:0] sndin2;
    logic [15:0] sndout2;
    logic        stb2;
    logic        mute2  = 1'b0;
    logic        pause2 = 1'b0;
    bit          min_done = 1'b0;

    always #5 clk = ~clk;

    ninjakun_snd_filter #(.DIV(DIV), .DC_SHIFT(DC_SHIFT), .LP_SHIFT(LP_SHIFT)) dut (
        .SHCLK (clk),
        .RESET (rst),
        .SNDIN (sndin),
        .MUTE  (mute),
        .pause (pause),
        .SNDOUT(sndout),
        .SNDSTB(stb)
    );

    ninjakun_snd_filter #(.DIV(4), .DC_SHIFT(DC_SHIFT), .LP_SHIFT(0)) dut_min (
        .SHCLK (clk),
        .RESET (rst2),
        .SNDIN (sndin2),
        .MUTE  (mute2),
        .pause (pause2),
        .SNDOUT(sndout2),
        .SNDSTB(stb2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Called at posedge+1; returns cycles advanced until a strobe is seen, -1 on timeout.
    task automatic wait_strobe(input bit which, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (which ? stb2 : stb) return;
        end
        n = -1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: divider counted in unpaused cycles, whole filter evaluated per sample.
    typedef struct {
        int          due;
        logic [15:0] val;
    } pend_t;

    pend_t       pend[$];
    int          m_cnt, m_acyc, m_x, m_d, m_xp, m_yp, m_l;
    logic [15:0] m_out;
    logic        exp_stb;

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767) return 16'h7fff;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_acyc = 0;
            m_xp   = 0;
            m_yp   = 0;
            m_l    = 0;
            m_out  = 16'h0000;
            pend.delete();
        end else begin
            exp_stb = 1'b0;
            if (!pause && pend.size() > 0) begin
                if (pend[0].due == m_acyc) begin
                    exp_stb = 1'b1;
                    m_out   = pend[0].val;
                    pend.delete(0);
                end
            end
            check("model_strobe", int'(stb), int'(exp_stb));
            check("model_sndout", int'(sndout), int'(m_out));
            if (!pause) begin
                if (m_cnt == DIV - 1) begin
                    m_x = mute ? 0 : int'(sndin) - 32768;
`ifdef SNDFLT_DCBLOCK_EN
                    m_d  = m_x - m_xp + m_yp - (m_yp >>> DC_SHIFT);
                    m_xp = m_x;
                    m_yp = m_d;
`else
                    m_d = m_x;
`endif
                    m_l = m_l + ((m_d - m_l) >>> LP_SHIFT);
                    pend.push_back('{due: m_acyc + 3, val: sat16(m_l)});
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
                m_acyc++;
            end
        end
    end

    typedef struct {
        logic [15:0] sndin;
        logic        mute;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[5];

    // Minimum divider, LP_SHIFT = 0: range limits and 4-cycle strobe period.
    initial begin
        int n;
        rst2   = 1'b1;
        sndin2 = 16'hffff;
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        wait_strobe(1'b1, 20, n);
        check("min_first_strobe", n, 6);
        check("min_full_scale_pos", int'(sndout2), 16'h7fff);
        sndin2 = 16'h0000;
        wait_strobe(1'b1, 20, n);
        check("min_strobe_period", n, 4);
        check("min_full_scale_neg", int'(sndout2), 16'h8000);
        min_done = 1'b1;
    end

    initial begin
        int          n;
        int          seen;
        int          pause_left;
        logic [15:0] held;

`ifdef SNDFLT_DCBLOCK_EN
        vecs[0] = '{16'hc000, 1'b0, 16'h1000};
        vecs[1] = '{16'hc000, 1'b0, 16'h1bfc};
        vecs[2] = '{16'hc000, 1'b0, 16'h24f5};
        vecs[3] = '{16'hffff, 1'b1, 16'h1bac};
        vecs[4] = '{16'h0000, 1'b0, 16'hf4b5};
`else
        vecs[0] = '{16'hc000, 1'b0, 16'h1000};
        vecs[1] = '{16'hc000, 1'b0, 16'h1c00};
        vecs[2] = '{16'hc000, 1'b0, 16'h2500};
        vecs[3] = '{16'hffff, 1'b1, 16'h1bc0};
        vecs[4] = '{16'h0000, 1'b0, 16'hf4d0};
`endif

        rst   = 1'b1;
        pause = 1'b0;
        mute  = 1'b0;
        sndin = 16'h8000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_sndout", int'(sndout), 0);
        check("reset_strobe", int'(stb), 0);

        // Mid-scale input: strobes at 502 then every DIV cycles, output stays zero.
        wait_strobe(1'b0, 600, n);
        check("first_strobe_cycle", n, 502);
        check("silence_out", int'(sndout), 0);
        wait_strobe(1'b0, 600, n);
        check("strobe_period", n, 500);

        // Vector table from a clean filter state.
        sndin = vecs[0].sndin;
        mute  = vecs[0].mute;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            wait_strobe(1'b0, 600, n);
            check($sformatf("vec%0d_timing", i), n, (i == 0) ? 502 : 500);
            check($sformatf("vec%0d_sndout", i), int'(sndout), int'(vecs[i].expv));
            if (i < 4) begin
                sndin = vecs[i + 1].sndin;
                mute  = vecs[i + 1].mute;
            end
        end

        // Pause covering the tick cycle: nothing during pause, strobe 3 cycles after release.
        mute  = 1'b0;
        sndin = 16'h1234;
        repeat (497) @(posedge clk);
        #1;
        pause = 1'b1;
        held  = sndout;
        seen  = 0;
        for (int i = 0; i < 1000; i++) begin
            if (stb) seen++;
            @(posedge clk);
            #1;
        end
        check("pause_no_strobe", seen, 0);
        check("pause_holds_out", int'(sndout), int'(held));
        pause = 1'b0;
        wait_strobe(1'b0, 10, n);
        check("pause_release_latency", n, 3);

        // Pause with a sample in flight: pipeline resumes where it stopped.
        sndin = 16'h6789;
        repeat (498) @(posedge clk);
        #1;
        pause = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        pause = 1'b0;
        wait_strobe(1'b0, 10, n);
        check("pause_inflight_resume", n, 2);

        // Reset one cycle after a tick discards that sample.
        sndin = 16'h8000;
        repeat (498) @(posedge clk);
        #1;
        pulse_reset();
        check("reset_clears_out", int'(sndout), 0);
        wait_strobe(1'b0, 600, n);
        check("reset_discards_inflight", n, 502);
        check("reset_then_silence", int'(sndout), 0);

        // Random stimulus against the reference model.
        pause_left = 0;
        for (int i = 0; i < 30000; i++) begin
            sndin = 16'($urandom);
            mute  = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 9999) == 0);
            if (pause_left > 0) begin
                pause_left--;
                pause = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                pause_left = $urandom_range(1, 600);
                pause      = 1'b1;
            end else begin
                pause = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        pause = 1'b0;
        repeat (1100) @(posedge clk);
        #1;

        wait (min_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
